// File: rtl/mixcol_engine.sv
// AES MixColumns engine: read, transform and write back num_blocks SRAM words in place.
// Define MIXCOL_INV_EN to build InvMixColumns and honour the inverse port.
module mixcol_engine #(
   parameter int ADDR_W    = 16,
   parameter int BASE_ADDR = 32,
   parameter int ADDR_STEP = 1,
   parameter int CNT_W     = 3,
   parameter int READ_LAT  = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              inverse,
   input  logic [CNT_W-1:0]  num_blocks,
   input  logic [127:0]      sram_rdata,
   output logic [127:0]      sram_wdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_read,
   output logic              sram_write,
   output logic              busy,
   output logic              done
);

   localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      COMPUTE,
      WR,
      FIN
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [CNT_W-1:0]  idx_q;
   logic [CNT_W-1:0]  idx_inc;
   logic [CNT_W-1:0]  nblk_q;
   logic [WAIT_W-1:0] wait_q;
   logic              wait_last;
   logic [127:0]      data_q;
   logic [127:0]      result_q;
   logic [127:0]      result_d;
   logic [ADDR_W-1:0] blk_addr;
   logic              addr_en;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m3(input logic [7:0] b);
      return xt(b) ^ b;
   endfunction

   function automatic logic [127:0] mix_fwd(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*c -: 8];
         a1 = s[95-8*c -: 8];
         a2 = s[63-8*c -: 8];
         a3 = s[31-8*c -: 8];
         o[127-8*c -: 8] = xt(a0) ^ m3(a1) ^ a2 ^ a3;
         o[95-8*c -: 8]  = a0 ^ xt(a1) ^ m3(a2) ^ a3;
         o[63-8*c -: 8]  = a0 ^ a1 ^ xt(a2) ^ m3(a3);
         o[31-8*c -: 8]  = m3(a0) ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

`ifdef MIXCOL_INV_EN
   logic inv_q;

   function automatic logic [7:0] m9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] md(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] me(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   function automatic logic [127:0] mix_inv(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*c -: 8];
         a1 = s[95-8*c -: 8];
         a2 = s[63-8*c -: 8];
         a3 = s[31-8*c -: 8];
         o[127-8*c -: 8] = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
         o[95-8*c -: 8]  = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
         o[63-8*c -: 8]  = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
         o[31-8*c -: 8]  = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
      end
      return o;
   endfunction

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         inv_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         inv_q <= inverse;
      end
   end

   assign result_d = inv_q ? mix_inv(data_q) : mix_fwd(data_q);
`else
   logic unused_inverse;

   assign unused_inverse = inverse;
   assign result_d       = mix_fwd(data_q);
`endif

   assign idx_inc   = idx_q + CNT_W'(1);
   assign wait_last = (wait_q == WAIT_W'(READ_LAT - 1));
   assign blk_addr  = ADDR_W'(BASE_ADDR)
                    + ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sram_read  = 1'b0;
      sram_write = 1'b0;
      addr_en    = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = (num_blocks == '0) ? FIN : RD_REQ;
            end
         end
         RD_REQ: begin
            sram_read = 1'b1;
            addr_en   = 1'b1;
            state_d   = RD_WAIT;
         end
         RD_WAIT: begin
            addr_en = 1'b1;
            if (wait_last) begin
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            state_d = WR;
         end
         WR: begin
            sram_write = 1'b1;
            addr_en    = 1'b1;
            state_d    = (idx_inc < nblk_q) ? RD_REQ : FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sram_addr  = addr_en ? blk_addr : '0;
   assign sram_wdata = result_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx_q    <= '0;
         nblk_q   <= '0;
         wait_q   <= '0;
         data_q   <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  nblk_q <= num_blocks;
                  idx_q  <= '0;
               end
            end
            RD_REQ: begin
               wait_q <= '0;
            end
            RD_WAIT: begin
               wait_q <= wait_q + WAIT_W'(1);
               if (wait_last) begin
                  data_q <= sram_rdata;
               end
            end
            COMPUTE: begin
               result_q <= result_d;
            end
            WR: begin
               idx_q <= idx_inc;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mixcol_engine.sv
// Scoreboard bench for mixcol_engine with a READ_LAT=2 SRAM model.
module tb_mixcol_engine;

   localparam int ADDR_W   = 16;
   localparam int CNT_W    = 3;
   localparam int READ_LAT = 2;

   localparam logic [127:0] A   = 128'hdbdbdbdb_13131313_53535353_45454545;
   localparam logic [127:0] A_F = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
   localparam logic [127:0] B   = 128'hf2f2f2f2_0a0a0a0a_22222222_5c5c5c5c;
   localparam logic [127:0] B_F = 128'h9f9f9f9f_dcdcdcdc_58585858_9d9d9d9d;
   localparam logic [127:0] C   = {16{8'hc6}};
   localparam logic [127:0] D   = {16{8'h01}};

   logic              clk = 1'b0;
   logic              n_rst = 1'b1;
   logic              start = 1'b0;
   logic              inverse = 1'b0;
   logic [CNT_W-1:0]  num_blocks = '0;
   logic [127:0]      sram_rdata;
   logic [127:0]      sram_wdata;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_read;
   logic              sram_write;
   logic              busy;
   logic              done;

   logic [127:0] mem [0:63];
   logic [127:0] rd_pipe;
   logic         ld_en = 1'b0;
   logic [5:0]   ld_addr = '0;
   logic [127:0] ld_data = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_cnt   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int busy_cnt = 0;

   logic [ADDR_W-1:0] exp_rd_q [$];
   logic [ADDR_W-1:0] exp_wa_q [$];
   logic [127:0]      exp_wd_q [$];

   always #5 clk = ~clk;

   mixcol_engine #(
      .ADDR_W(ADDR_W),
      .BASE_ADDR(32),
      .ADDR_STEP(1),
      .CNT_W(CNT_W),
      .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .start(start),
      .inverse(inverse),
      .num_blocks(num_blocks),
      .sram_rdata(sram_rdata),
      .sram_wdata(sram_wdata),
      .sram_addr(sram_addr),
      .sram_read(sram_read),
      .sram_write(sram_write),
      .busy(busy),
      .done(done)
   );

   // SRAM: data for a read strobe appears two edges later
   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (sram_write) mem[sram_addr[5:0]] <= sram_wdata;
      rd_pipe    <= sram_read ? mem[sram_addr[5:0]] : '0;
      sram_rdata <= rd_pipe;
   end

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (sram_read || sram_write)
         check("rd_wr_excl", 128'(sram_read & sram_write), 128'd0);
      if (sram_read) begin
         rd_cnt++;
         if (exp_rd_q.size() == 0)
            check("unexpected_read", 128'(sram_addr), 128'd0 - 1);
         else
            check("rd_addr", 128'(sram_addr), 128'(exp_rd_q.pop_front()));
      end
      if (sram_write) begin
         wr_cnt++;
         if (exp_wa_q.size() == 0)
            check("unexpected_write", 128'(sram_addr), 128'd0 - 1);
         else begin
            check("wr_addr", 128'(sram_addr), 128'(exp_wa_q.pop_front()));
            check("wr_data", sram_wdata, exp_wd_q.pop_front());
         end
      end
   end

   task automatic load(input int a, input logic [127:0] d);
      @(negedge clk);
      ld_en = 1'b1;
      ld_addr = a[5:0];
      ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic expect_blk(input int a, input logic [127:0] d);
      exp_rd_q.push_back(ADDR_W'(a));
      exp_wa_q.push_back(ADDR_W'(a));
      exp_wd_q.push_back(d);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_wdata"}, sram_wdata, 128'd0);
      check({tag, "_addr"}, 128'(sram_addr), 128'd0);
      check({tag, "_read"}, 128'(sram_read), 128'd0);
      check({tag, "_write"}, 128'(sram_write), 128'd0);
      check({tag, "_busy"}, 128'(busy), 128'd0);
      check({tag, "_done"}, 128'(done), 128'd0);
   endtask

   task automatic run_op(input int n, input logic inv, input int exp_cyc,
                         input bit toggle, input string tag);
      int c;
      @(negedge clk);
      rd_cnt = 0;
      wr_cnt = 0;
      done_cnt = 0;
      busy_cnt = 0;
      start = 1'b1;
      inverse = inv;
      num_blocks = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (!done && c < 200) begin
         if (toggle) begin
            start = c[0];
            inverse = ~inverse;
            num_blocks = CNT_W'(c);
         end
         @(negedge clk);
         c++;
      end
      start = 1'b0;
      inverse = 1'b0;
      check({tag, "_done_cycle"}, 128'(c), 128'(exp_cyc));
      @(negedge clk);
      @(negedge clk);
      check({tag, "_done_cnt"}, 128'(done_cnt), 128'd1);
      check({tag, "_rd_cnt"}, 128'(rd_cnt), 128'(n));
      check({tag, "_wr_cnt"}, 128'(wr_cnt), 128'(n));
      check({tag, "_busy_cnt"}, 128'(busy_cnt), 128'(exp_cyc));
   endtask

   initial begin
      #2 n_rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      n_rst = 1'b1;

      // forward, single block
      load(32, A);
      expect_blk(32, A_F);
      run_op(1, 1'b0, 6, 1'b0, "fwd1");
      check("fwd1_mem32", mem[32], A_F);

`ifdef MIXCOL_INV_EN
      load(32, A_F);
      expect_blk(32, A);
      run_op(1, 1'b1, 6, 1'b0, "inv1");
      check("inv1_mem32", mem[32], A);
`else
      // inverse request must still produce the forward result
      load(32, A);
      expect_blk(32, A_F);
      run_op(1, 1'b1, 6, 1'b0, "inv1");
      check("inv1_mem32", mem[32], A_F);
`endif

      // three blocks
      load(32, B);
      load(33, C);
      load(34, D);
      expect_blk(32, B_F);
      expect_blk(33, C);
      expect_blk(34, D);
      run_op(3, 1'b0, 16, 1'b0, "multi");
      check("multi_mem32", mem[32], B_F);
      check("multi_mem33", mem[33], C);
      check("multi_mem34", mem[34], D);

      // zero blocks
      run_op(0, 1'b0, 1, 1'b0, "zero");

      // start/inverse toggling while busy
      load(32, A);
      load(33, B);
      expect_blk(32, A_F);
      expect_blk(33, B_F);
      run_op(2, 1'b0, 11, 1'b1, "tog");
      check("tog_mem32", mem[32], A_F);
      check("tog_mem33", mem[33], B_F);

      // reset during the first block's read wait
      load(32, A);
      load(33, B);
      exp_rd_q.push_back(ADDR_W'(32));
      @(negedge clk);
      start = 1'b1;
      num_blocks = CNT_W'(2);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_busy_before", 128'(busy), 128'd1);
      n_rst = 1'b0;
      #1;
      check_idle_outputs("abort");
      repeat (4) @(negedge clk);
      n_rst = 1'b1;
      check("abort_mem32", mem[32], A);
      check("abort_mem33", mem[33], B);
      check("abort_rd_q", 128'(exp_rd_q.size()), 128'd0);

      expect_blk(32, A_F);
      expect_blk(33, B_F);
      run_op(2, 1'b0, 11, 1'b0, "post_rst");
      check("post_rst_mem32", mem[32], A_F);
      check("post_rst_mem33", mem[33], B_F);

      check("rd_q_empty", 128'(exp_rd_q.size()), 128'd0);
      check("wr_q_empty", 128'(exp_wa_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
